// File: rtl/vga_tile_fb.sv
// Tile-framebuffer pixel source: maps the 640x480 timing stream onto an 80x60 grid of
// 6-bit tile colours held in a single-port RAM shared by display, clear engine and host.
`timescale 1ns/1ps
module vga_tile_fb #(
    parameter int          TILE_COLS   = 80,
    parameter int          TILE_ROWS   = 60,
    parameter logic [5:0]  CLEAR_COLOR = 6'b00_00_00,
    parameter int          ADDR_W      = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_ce,
    input  logic [9:0]        in_cnt_h,
    input  logic [9:0]        in_cnt_v,
    input  logic              in_de,
    input  logic              in_sync_h,
    input  logic              in_sync_v,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [5:0]        wr_data,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done,
    output logic [5:0]        vga_rgb,
    output logic              vga_sync_h,
    output logic              vga_sync_v,
    output logic              out_de
);

    localparam int                DEPTH = TILE_COLS * TILE_ROWS;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;

    logic [6:0]        tile_h;
    logic [6:0]        tile_v;
    logic [ADDR_W-1:0] rd_addr;
    logic              disp_rd;
    logic              clr_wr;
    logic              host_wr;
    logic              unused_lsbs;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [5:0]        ram_wdata;
    logic [5:0]        ram_q;
    logic [5:0]        mem [DEPTH];

    logic              s1_de;
    logic              s1_sync_h;
    logic              s1_sync_v;

    // Row*80 built from two shifts so no multiplier is needed.
    assign tile_h      = in_cnt_h[9:3];
    assign tile_v      = in_cnt_v[9:3];
    assign rd_addr     = (ADDR_W'(tile_v) << 6) + (ADDR_W'(tile_v) << 4) + ADDR_W'(tile_h);
    assign unused_lsbs = ^{in_cnt_h[2:0], in_cnt_v[2:0]};

    assign disp_rd  = pix_ce && in_de;
    assign clr_wr   = (state == CLEAR) && !disp_rd;
    assign wr_ready = !disp_rd && (state == IDLE);
    assign host_wr  = wr_valid && wr_ready && (wr_addr < ADDR_W'(DEPTH));

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = rd_addr;
        ram_wdata = CLEAR_COLOR;
        if (disp_rd) begin
            ram_en = 1'b1;
        end else if (clr_wr) begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = clr_cnt;
        end else if (host_wr) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = wr_addr;
            ram_wdata = wr_data;
        end
    end

    // ram_q only changes on display reads, so it holds between pixel enables.
    always_ff @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
            end else begin
                ram_q <= mem[ram_addr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_de      <= 1'b0;
            s1_sync_h  <= 1'b1;
            s1_sync_v  <= 1'b1;
            vga_rgb    <= '0;
            out_de     <= 1'b0;
            vga_sync_h <= 1'b1;
            vga_sync_v <= 1'b1;
        end else if (pix_ce) begin
            s1_de      <= in_de;
            s1_sync_h  <= in_sync_h;
            s1_sync_v  <= in_sync_v;
            vga_rgb    <= s1_de ? ram_q : '0;
            out_de     <= s1_de;
            vga_sync_h <= s1_sync_h;
            vga_sync_v <= s1_sync_v;
        end
    end

    // Clear engine only advances on cycles the display leaves the port free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            clr_cnt    <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state      <= CLEAR;
                        clr_cnt    <= '0;
                        clear_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_wr) begin
                        if (clr_cnt == LAST) begin
                            state      <= IDLE;
                            clr_cnt    <= '0;
                            clear_busy <= 1'b0;
                            clear_done <= 1'b1;
                        end else begin
                            clr_cnt <= clr_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    clear_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_tile_fb.sv
// Randomised bench for vga_tile_fb: drives the timing stream cycle by cycle and compares
// every output against a tile-array model of the framebuffer and the clear/host rules.
`timescale 1ns/1ps
module tb_vga_tile_fb;

    localparam int         NT     = 4800;
    localparam logic [5:0] CLRCOL = 6'b00_00_00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_ce = 1'b0;
    logic [9:0]  in_cnt_h = '0;
    logic [9:0]  in_cnt_v = '0;
    logic        in_de = 1'b0;
    logic        in_sync_h = 1'b1;
    logic        in_sync_v = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [12:0] wr_addr = '0;
    logic [5:0]  wr_data = '0;
    logic        clear_req = 1'b0;
    logic        clear_busy;
    logic        clear_done;
    logic [5:0]  vga_rgb;
    logic        vga_sync_h;
    logic        vga_sync_v;
    logic        out_de;

    vga_tile_fb dut (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
        .in_cnt_h(in_cnt_h), .in_cnt_v(in_cnt_v), .in_de(in_de),
        .in_sync_h(in_sync_h), .in_sync_v(in_sync_v),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done),
        .vga_rgb(vga_rgb), .vga_sync_h(vga_sync_h), .vga_sync_v(vga_sync_v), .out_de(out_de)
    );

    always #10 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [5:0]  mem_m [NT];
    bit          m_busy = 0;
    bit          m_done = 0;
    int          m_cnt = 0;
    logic [8:0]  prev_exp = {6'd0, 1'b0, 1'b1, 1'b1};
    logic [8:0]  out_exp  = {6'd0, 1'b0, 1'b1, 1'b1};
    bit          auto_wr = 0;
    bit          accepted = 0;
    bit          req_next = 0;
    int          dut_done_count = 0;
    int          dut_busy_cycles = 0;

    // Expected {rgb, de, sync_h, sync_v} for a pixel, from the current tile contents.
    function automatic logic [8:0] pix_model(input int h, input int v);
        bit         de;
        bit         hs;
        bit         vs;
        logic [5:0] c;
        de = (h < 640) && (v < 480);
        hs = !(h >= 656 && h < 752);
        vs = !(v >= 490 && v < 492);
        c  = de ? mem_m[(v / 8) * 80 + h / 8] : 6'd0;
        return {c, de, hs, vs};
    endfunction

    task automatic pick_auto_write();
        if ($urandom_range(0, 7) == 0)
            wr_addr = 13'($urandom_range(4800, 8191));
        else
            wr_addr = 13'($urandom_range(0, 1) * 80 + $urandom_range(0, 24));
        wr_data = 6'($urandom);
    endtask

    task automatic clk_cycle(input bit ce, input int h, input int v);
        bit         disp;
        bit         rdy_exp;
        bit         acc;
        logic [8:0] cur;
        pix_ce    = ce;
        in_cnt_h  = h[9:0];
        in_cnt_v  = v[9:0];
        in_de     = (h < 640) && (v < 480);
        in_sync_h = !(h >= 656 && h < 752);
        in_sync_v = !(v >= 490 && v < 492);
        clear_req = req_next;
        #1;
        disp    = ce && in_de;
        rdy_exp = !disp && !m_busy;
        checks++;
        if (wr_ready !== rdy_exp) begin
            failures++;
            $display("[TB] FAIL wr_ready t=%0t got=%b exp=%b", $time, wr_ready, rdy_exp);
        end
        acc = wr_valid && rdy_exp;
        cur = pix_model(h, v);
        @(posedge clk);
        #1;
        if (acc && wr_addr < NT) mem_m[wr_addr] = wr_data;
        m_done = 0;
        if (m_busy) begin
            if (!disp) begin
                mem_m[m_cnt] = CLRCOL;
                m_cnt++;
                if (m_cnt == NT) begin
                    m_busy = 0;
                    m_cnt  = 0;
                    m_done = 1;
                end
            end
        end else if (req_next) begin
            m_busy = 1;
            m_cnt  = 0;
        end
        req_next  = 0;
        clear_req = 1'b0;
        if (ce) begin
            out_exp  = prev_exp;
            prev_exp = cur;
        end
        checks++;
        if ({vga_rgb, out_de, vga_sync_h, vga_sync_v} !== out_exp) begin
            failures++;
            $display("[TB] FAIL pixel_out t=%0t got rgb=%h de=%b hs=%b vs=%b exp rgb=%h de=%b hs=%b vs=%b",
                     $time, vga_rgb, out_de, vga_sync_h, vga_sync_v,
                     out_exp[8:3], out_exp[2], out_exp[1], out_exp[0]);
        end
        checks++;
        if ({clear_busy, clear_done} !== {m_busy, m_done}) begin
            failures++;
            $display("[TB] FAIL clear_flags t=%0t got busy=%b done=%b exp busy=%b done=%b",
                     $time, clear_busy, clear_done, m_busy, m_done);
        end
        if (clear_done === 1'b1) dut_done_count++;
        if (clear_busy === 1'b1) dut_busy_cycles++;
        accepted = acc;
        if (acc && auto_wr) pick_auto_write();
    endtask

    task automatic show_pixel(input int h, input int v);
        clk_cycle(1, h, v);
        clk_cycle(0, h, v);
    endtask

    task automatic flush();
        show_pixel(700, 500);
        show_pixel(700, 500);
    endtask

    task automatic host_write(input int addr, input logic [5:0] data);
        int n = 0;
        wr_valid = 1'b1;
        wr_addr  = 13'(addr);
        wr_data  = data;
        accepted = 0;
        while (!accepted && n < 50) begin
            clk_cycle(0, 700, 500);
            n++;
        end
        wr_valid = 1'b0;
        checks++;
        if (!accepted) begin
            failures++;
            $display("[TB] FAIL host_write_timeout addr=%0d got=not_accepted exp=accepted", addr);
        end
    endtask

    task automatic do_reset();
        pix_ce    = 1'b0;
        wr_valid  = 1'b0;
        clear_req = 1'b0;
        rst_n     = 1'b0;
        #1;
        checks++;
        if ({vga_rgb, out_de, vga_sync_h, vga_sync_v, clear_busy, clear_done} !== {6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL reset_immediate got rgb=%h de=%b hs=%b vs=%b busy=%b done=%b exp 00 0 1 1 0 0",
                     vga_rgb, out_de, vga_sync_h, vga_sync_v, clear_busy, clear_done);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({vga_rgb, out_de, vga_sync_h, vga_sync_v, clear_busy, clear_done} !== {6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL reset_held got rgb=%h de=%b hs=%b vs=%b busy=%b done=%b exp 00 0 1 1 0 0",
                     vga_rgb, out_de, vga_sync_h, vga_sync_v, clear_busy, clear_done);
        end
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_busy   = 0;
        m_done   = 0;
        m_cnt    = 0;
        req_next = 0;
        prev_exp = {6'd0, 1'b0, 1'b1, 1'b1};
        out_exp  = {6'd0, 1'b0, 1'b1, 1'b1};
    endtask

    task automatic readback_all();
        for (int t = 0; t < NT; t++)
            show_pixel((t % 80) * 8 + $urandom_range(0, 7), (t / 80) * 8 + $urandom_range(0, 7));
        flush();
    endtask

    task automatic run_clear_blanking(output int done_delta);
        int start = dut_done_count;
        int n = 0;
        req_next = 1;
        clk_cycle(0, 700, 500);
        while (m_busy && n < 12000) begin
            clk_cycle(n % 2 == 0, 700, 500);
            n++;
        end
        checks++;
        if (m_busy) begin
            failures++;
            $display("[TB] FAIL clear_timeout got=busy exp=idle");
        end
        clk_cycle(0, 700, 500);
        done_delta = dut_done_count - start;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        do_reset();
    endtask

    task automatic test_clear();
        int d;
        $display("[TB] test_clear");
        run_clear_blanking(d);
        checks++;
        if (d != 1) begin
            failures++;
            $display("[TB] FAIL clear_done_count got=%0d exp=1", d);
        end
        readback_all();
    endtask

    task automatic test_latency();
        $display("[TB] test_latency");
        host_write(0, 6'h30);
        host_write(81, 6'h0C);
        for (int h = 0; h < 20; h++) show_pixel(h, 0);
        for (int h = 0; h < 20; h++) show_pixel(h, 8);
        for (int h = 630; h < 680; h++) show_pixel(h, 0);
        flush();
    endtask

    task automatic test_arbitration();
        $display("[TB] test_arbitration");
        auto_wr  = 1;
        pick_auto_write();
        wr_valid = 1'b1;
        for (int v = 0; v < 16; v++)
            for (int h = 0; h < 200; h++) show_pixel(h, v);
        wr_valid = 1'b0;
        auto_wr  = 0;
        for (int v = 0; v < 16; v++)
            for (int h = 0; h < 200; h++) show_pixel(h, v);
        flush();
    endtask

    task automatic test_out_of_range();
        $display("[TB] test_out_of_range");
        host_write(0, 6'h30);
        host_write(159, 6'h15);
        host_write(167, 6'h2A);
        host_write(4799, 6'h07);
        host_write(4800, 6'h3F);
        show_pixel(0, 0);
        show_pixel(639, 479);
        for (int h = 630; h < 712; h++) show_pixel(h, 8);
        show_pixel(10, 500);
        show_pixel(700, 0);
        show_pixel(639, 479);
        flush();
    endtask

    task automatic test_clear_during_display();
        int start = dut_done_count;
        int n = 0;
        int h;
        int v;
        $display("[TB] test_clear_during_display");
        req_next = 1;
        show_pixel(700, 500);
        while (m_busy && n < 20000) begin
            if (n == 600) req_next = 1;
            h = $urandom_range(0, 799);
            v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 524) : $urandom_range(0, 479);
            show_pixel(h, v);
            n++;
        end
        checks++;
        if (m_busy) begin
            failures++;
            $display("[TB] FAIL clear_display_timeout got=busy exp=idle");
        end
        flush();
        checks++;
        if (dut_done_count - start != 1) begin
            failures++;
            $display("[TB] FAIL clear_restart_done_count got=%0d exp=1", dut_done_count - start);
        end
        readback_all();
    endtask

    task automatic test_async_reset();
        $display("[TB] test_async_reset");
        host_write(0, 6'h30);
        show_pixel(0, 0);
        show_pixel(1, 0);
        clk_cycle(1, 2, 0);
        do_reset();
    endtask

    task automatic test_reset_mid_clear();
        int start;
        int busy0;
        int d;
        int n = 0;
        $display("[TB] test_reset_mid_clear");
        host_write(0, 6'h2B);
        host_write(2500, 6'h11);
        host_write(4799, 6'h3E);
        req_next = 1;
        clk_cycle(0, 700, 500);
        while (m_cnt < 2000 && n < 5000) begin
            clk_cycle(n % 2 == 0, 700, 500);
            n++;
        end
        start = dut_done_count;
        do_reset();
        for (int i = 0; i < 4; i++) clk_cycle(i % 2 == 0, 700, 500);
        checks++;
        if (dut_done_count != start) begin
            failures++;
            $display("[TB] FAIL abort_done got=%0d_pulses exp=0", dut_done_count - start);
        end
        busy0 = dut_busy_cycles;
        run_clear_blanking(d);
        checks++;
        if (d != 1) begin
            failures++;
            $display("[TB] FAIL restart_done_count got=%0d exp=1", d);
        end
        checks++;
        if (dut_busy_cycles - busy0 != NT) begin
            failures++;
            $display("[TB] FAIL restart_busy_cycles got=%0d exp=%0d", dut_busy_cycles - busy0, NT);
        end
        show_pixel(0, 0);
        show_pixel(4 * 8, 31 * 8);
        show_pixel(639, 479);
        show_pixel(20 * 8, 31 * 8);
        flush();
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_clear();
        test_latency();
        test_arbitration();
        test_out_of_range();
        test_clear_during_display();
        test_async_reset();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #4_000_000;
        $display("[TB] FAIL watchdog got=running exp=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/vga_tile_fb.md
Name: vga_tile_fb

Overview:
- Pixel-source stage directly upstream of the VGA colour output. Consumes the 640x480 timing stream (counters, display-enable, syncs) and produces the 6-bit RGB pixel with syncs re-aligned.
- Colour comes from an internal 80x60 tile framebuffer (one 6-bit colour per 8x8 pixel tile), held in single-port synchronous RAM.
- A host write port fills the RAM. A clear engine fills the whole RAM with one colour.

Parameters:
- TILE_COLS, 80, tiles per row (640/8)
- TILE_ROWS, 60, tiles per column (480/8)
- CLEAR_COLOR, 6'b00_00_00, colour written by the clear engine
- ADDR_W, 13, framebuffer address width (covers 4800 entries)

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- pix_ce  in  1  pixel clock enable, one clk cycle in two (25 MHz pixel rate)
- in_cnt_h  in  10  horizontal pixel counter, valid when pix_ce
- in_cnt_v  in  10  vertical line counter, valid when pix_ce
- in_de  in  1  display region flag
- in_sync_h  in  1  horizontal sync, active-low
- in_sync_v  in  1  vertical sync, active-low
- wr_valid  in  1  host write request
- wr_ready  out  1  host write accepted this cycle
- wr_addr  in  13  tile index, row*80+col
- wr_data  in  6  tile colour {R[1:0],G[1:0],B[1:0]}
- clear_req  in  1  one-cycle pulse: start full clear
- clear_busy  out  1  clear engine active
- clear_done  out  1  one-cycle pulse when clear completes
- vga_rgb  out  6  pixel colour
- vga_sync_h  out  1  delayed horizontal sync, active-low
- vga_sync_v  out  1  delayed vertical sync, active-low
- out_de  out  1  delayed display enable

Behaviour:
Reset (async, rst_n=0):
- vga_rgb=0, vga_sync_h=1, vga_sync_v=1, out_de=0.
- clear_busy=0, clear_done=0, FSM=IDLE, clear counter=0, pipeline registers=0 (sync registers=1).
- RAM contents undefined after reset and not initialised; firmware issues clear_req.

Display pipeline (advances only when pix_ce=1):
- Stage 1: read address = (cnt_v>>3)*80 + (cnt_h>>3), computed as (v<<6)+(v<<4)+h on tile indices with no multiplier. Issue RAM read when in_de=1. Register in_de and both syncs.
- Stage 2: vga_rgb = RAM data if stage-1 de=1, else 0. out_de and syncs come from stage 1.
- Latency: exactly 2 pix_ce pulses for rgb, de and syncs alike, so outputs stay mutually aligned.
- Outputs hold between pix_ce pulses.

RAM port arbitration (single port, per clk cycle):
- Priority 1: display read, when pix_ce=1 and in_de=1.
- Priority 2: clear engine write, when FSM=CLEAR.
- Priority 3: host write.
- wr_ready = !(pix_ce && in_de) && (FSM==IDLE). It is combinational from these terms only; it does not depend on wr_valid.
- A write is accepted when wr_valid && wr_ready, and is committed in the same cycle.
- wr_addr >= 4800: still accepted (wr_ready honoured), data dropped, no RAM change.
- Host must hold wr_valid, wr_addr and wr_data stable until accepted.

Clear FSM:
- IDLE to CLEAR on clear_req=1.
- CLEAR: on each cycle where the port is free of a display read, write CLEAR_COLOR at counter, then counter += 1.
- When the write at counter=4799 commits: counter -> 0, FSM -> IDLE, clear_done=1 for exactly one cycle.
- clear_busy=1 exactly while FSM=CLEAR.
- clear_req while in CLEAR is ignored; it does not restart the clear.
- clear_req in the same cycle as a host write: the host write is accepted (wr_ready was evaluated while still in IDLE), then the clear starts next cycle and overwrites it.
- Reset mid-clear aborts: FSM=IDLE, no clear_done.

Boundary conditions:
- Tile coordinates are cnt>>3, and the display read is gated by in_de. cnt_h 640..799 and cnt_v 480..524 never read RAM and force rgb=0.
- Last pixel (639,479) reads tile 4799.

Test Plan:
- Reset: drive rst_n=0 mid-frame -> vga_rgb=0, syncs=1, out_de=0, clear_busy=0 immediately, without waiting for a clk edge.
- Latency and alignment: write tile 0=6'h30, tile 81=6'h0C. Run timing stream. Pixels (0..7,0) -> 6'h30 and (8..15,8) -> 6'h0C, each on the 2nd pix_ce after input. hsync falling edge is also delayed by exactly 2 pix_ce.
- Arbitration: hold wr_valid=1 during active video -> wr_ready=0 on every cycle with pix_ce && in_de, 1 on the other cycles. Write lands and reads back correctly next frame, with no corruption of displayed pixels.
- Clear: clear_req in IDLE -> clear_busy=1, wr_ready=0 throughout. All 4800 tiles read CLEAR_COLOR afterwards. clear_done pulses exactly once. A second clear_req mid-clear produces no extra clear_done.
- Out-of-range and blanking: write addr 4800 with 6'h3F -> accepted, tiles 0 and 4799 unchanged. Pixels at cnt_h=700 or cnt_v=500 -> vga_rgb=0.
- Reset mid-clear: assert rst_n=0 at counter≈2000 -> clear_busy=0, no clear_done. A new clear_req after reset runs the full 4800 writes.
